// File: rtl/avrspi_master_pkg.sv
// -----------------------------------------------------------------------------
// avrspi_master_pkg
// Shared definitions for the avrspi_master SPI master engine:
//   - frame FSM state encoding
//   - counter widths (bit, byte, nbytes)
//   - SPI mode 0 idle levels
//   - cnt_width(): counter width for a modulo-n counter (min 1 bit)
// -----------------------------------------------------------------------------
package avrspi_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam int BIT_CNT_W  = 3;  // wraps 7 -> 0 once per byte
  localparam int BYTE_CNT_W = 7;  // address byte plus up to 63 data bytes
  localparam int NBYTES_W   = 6;

  // Mode 0: clock idles low, data launched while the clock is low.
  localparam logic SPI_CK_IDLE = 1'b0;
  localparam logic SPI_DO_IDLE = 1'b0;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/avrspi_master_byteshift.sv
// -----------------------------------------------------------------------------
// avrspi_master_byteshift
// Bit engine of the SPI master: clock divider, spick generation, the 8-bit
// full-duplex shift register and the bit counter.
//
// Ports:
//   fclk, rst       clock, synchronous active-high reset
//   run             shift clock enabled (frame FSM in SHIFT)
//   clr             force idle levels on spick/spido, reset divider/bit count
//   load            load load_data into the shift register, bit 7 onto spido
//   load_data[7:0]  byte to transmit next
//   spidi           master-in serial data
//   spick, spido    SPI clock and master-out data
//   rise_last       this cycle ends with the 8th rising edge of a byte
//   fall_last       this cycle ends with the 8th falling edge of a byte
//   rx_byte[7:0]    byte completed by the rising edge at the end of this cycle
// -----------------------------------------------------------------------------
module avrspi_master_byteshift
  import avrspi_master_pkg::*;
#(
  parameter int CLKDIV = 4
) (
  input  logic       fclk,
  input  logic       rst,
  input  logic       run,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       spidi,
  output logic       spick,
  output logic       spido,
  output logic       rise_last,
  output logic       fall_last,
  output logic [7:0] rx_byte
);

  localparam int                DIV_W    = cnt_width(CLKDIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLKDIV - 1);

  logic [DIV_W-1:0]     div_q, div_d;
  logic [BIT_CNT_W-1:0] bit_q, bit_d;
  logic                 ck_q,  ck_d;
  logic                 do_q,  do_d;
  logic [7:0]           sh_q,  sh_d;
  logic                 ck_edge;

  // The divider expires at the end of each half-period; spick toggles then.
  assign ck_edge   = run & (div_q == DIV_LAST);
  assign rise_last = ck_edge & ~ck_q & (&bit_q);
  assign fall_last = ck_edge &  ck_q & (&bit_q);
  assign rx_byte   = {sh_q[6:0], spidi};

  // One register serves both directions: each rising edge shifts spidi in at
  // the bottom while the bit already launched on spido leaves at the top, so
  // after eight rising edges sh_q holds the received byte.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; a missing default here would infer a latch.
    div_d = div_q;
    bit_d = bit_q;
    ck_d  = ck_q;
    do_d  = do_q;
    sh_d  = sh_q;
    if (clr) begin
      div_d = '0;
      bit_d = '0;
      ck_d  = SPI_CK_IDLE;
      do_d  = SPI_DO_IDLE;
    end else begin
      if (run) begin
        if (ck_edge) begin
          div_d = '0;
          ck_d  = ~ck_q;
          if (!ck_q) begin
            sh_d = {sh_q[6:0], spidi};           // rising edge: sample
          end else begin
            bit_d = bit_q + BIT_CNT_W'(1);       // falling edge: next bit
            do_d  = sh_q[7];
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      // A load coincides with the byte's last falling edge (or frame start),
      // so it overrides the normal next-bit launch.
      if (load) begin
        sh_d = load_data;
        do_d = load_data[7];
      end
    end
  end

  always_ff @(posedge fclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      div_q <= '0;
      bit_q <= '0;
      ck_q  <= SPI_CK_IDLE;
      do_q  <= SPI_DO_IDLE;
      sh_q  <= '0;
    end else begin
      div_q <= div_d;
      bit_q <= bit_d;
      ck_q  <= ck_d;
      do_q  <= do_d;
      sh_q  <= sh_d;
    end
  end

  assign spick = ck_q;
  assign spido = do_q;

endmodule

// File: rtl/avrspi_master.sv
// -----------------------------------------------------------------------------
// avrspi_master
// SPI master (mode 0, MSB first) framing one register transaction per start:
// an address byte followed by nbytes full-duplex data bytes.
//
// Ports:
//   fclk, rst         clock, synchronous active-high reset
//   start             one-cycle frame request, honoured while idle
//   addr[7:0]         register address, latched on an accepted start
//   nbytes[5:0]       data bytes after the address, latched on an accepted start
//   abort             terminate the current frame immediately
//   busy              frame in progress
//   done              one-cycle pulse at normal frame completion
//   tx_ld             one-cycle pulse; tx_data is sampled at the end of it
//   tx_data[7:0]      next outgoing data byte
//   rx_stb            one-cycle pulse; rx_data valid
//   rx_data[7:0]      last received data byte, held until the next rx_stb
//   spics_n, spick, spido, spidi   SPI link
// -----------------------------------------------------------------------------
module avrspi_master
  import avrspi_master_pkg::*;
#(
  parameter int CLKDIV   = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic       fclk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [5:0] nbytes,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       tx_ld,
  input  logic [7:0] tx_data,
  output logic       rx_stb,
  output logic [7:0] rx_data,
  output logic       spics_n,
  output logic       spick,
  output logic       spido,
  input  logic       spidi
);

  localparam int TMR_W = cnt_width((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
  localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(CS_SETUP - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(CS_HOLD - 1);

  state_e                state_q, state_d;
  logic [TMR_W-1:0]      tmr_q,   tmr_d;
  logic [BYTE_CNT_W-1:0] byte_q,  byte_d;    // 0 = address byte
  logic [NBYTES_W-1:0]   nb_q,    nb_d;
  logic                  busy_q,  busy_d;
  logic                  cs_n_q,  cs_n_d;
  logic                  rx_stb_q, rx_stb_d;
  logic [7:0]            rx_data_q, rx_data_d;

  logic       bs_run, bs_clr, bs_load;
  logic [7:0] bs_load_data;
  logic       rise_last, fall_last;
  logic [7:0] rx_byte;

  avrspi_master_byteshift #(.CLKDIV(CLKDIV)) u_byteshift (
    .fclk      (fclk),
    .rst       (rst),
    .run       (bs_run),
    .clr       (bs_clr),
    .load      (bs_load),
    .load_data (bs_load_data),
    .spidi     (spidi),
    .spick     (spick),
    .spido     (spido),
    .rise_last (rise_last),
    .fall_last (fall_last),
    .rx_byte   (rx_byte)
  );

  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    byte_d       = byte_q;
    nb_d         = nb_q;
    busy_d       = busy_q;
    cs_n_d       = cs_n_q;
    rx_stb_d     = 1'b0;
    rx_data_d    = rx_data_q;
    tx_ld        = 1'b0;
    done         = 1'b0;
    bs_run       = 1'b0;
    bs_clr       = 1'b0;
    bs_load      = 1'b0;
    bs_load_data = tx_data;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          nb_d         = nbytes;
          byte_d       = '0;
          tmr_d        = '0;
          busy_d       = 1'b1;
          cs_n_d       = 1'b0;
          bs_load      = 1'b1;           // addr goes straight into the shifter
          bs_load_data = addr;
          state_d      = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (tmr_q == SETUP_LAST) begin
          tmr_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      ST_SHIFT: begin
        bs_run = 1'b1;
        // Data received during the address byte is discarded.
        if (rise_last && byte_q != '0) begin
          rx_stb_d  = 1'b1;
          rx_data_d = rx_byte;
        end
        if (fall_last) begin
          if (byte_q == BYTE_CNT_W'(nb_q)) begin
            bs_clr  = 1'b1;
            tmr_d   = '0;
            state_d = ST_HOLD;
          end else begin
            tx_ld   = 1'b1;
            bs_load = 1'b1;
            byte_d  = byte_q + BYTE_CNT_W'(1);
          end
        end
      end

      ST_HOLD: begin
        if (tmr_q == HOLD_LAST) begin
          done    = 1'b1;
          busy_d  = 1'b0;
          cs_n_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Abort overrides whatever the frame was about to do this cycle.
    if (abort && state_q != ST_IDLE) begin
      state_d   = ST_IDLE;
      busy_d    = 1'b0;
      cs_n_d    = 1'b1;
      rx_stb_d  = 1'b0;
      rx_data_d = rx_data_q;
      tx_ld     = 1'b0;
      done      = 1'b0;
      bs_load   = 1'b0;
      bs_clr    = 1'b1;
    end
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      byte_q    <= '0;
      nb_q      <= '0;
      busy_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      rx_stb_q  <= 1'b0;
      rx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      byte_q    <= byte_d;
      nb_q      <= nb_d;
      busy_q    <= busy_d;
      cs_n_q    <= cs_n_d;
      rx_stb_q  <= rx_stb_d;
      rx_data_q <= rx_data_d;
    end
  end

  assign busy    = busy_q;
  assign spics_n = cs_n_q;
  assign rx_stb  = rx_stb_q;
  assign rx_data = rx_data_q;

endmodule

// File: tb/tb_avrspi_master.sv
// -----------------------------------------------------------------------------
// tb_avrspi_master
// Drives framed transactions into avrspi_master, plays an SPI mode-0 slave on
// the link and compares every observed event against frame-level expectations
// derived from the timing formulas (busy length, tx_ld/rx_stb cycles, bytes).
// -----------------------------------------------------------------------------
module tb_avrspi_master;

  localparam int D = 2;   // CLKDIV
  localparam int S = 2;   // CS_SETUP
  localparam int H = 2;   // CS_HOLD

  logic       fclk = 1'b0;
  logic       rst, start, abort, spidi;
  logic [7:0] addr, tx_data;
  logic [5:0] nbytes;
  logic       busy, done, tx_ld, rx_stb, spics_n, spick, spido;
  logic [7:0] rx_data;

  avrspi_master #(.CLKDIV(D), .CS_SETUP(S), .CS_HOLD(H)) dut (
    .fclk    (fclk),
    .rst     (rst),
    .start   (start),
    .addr    (addr),
    .nbytes  (nbytes),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .tx_ld   (tx_ld),
    .tx_data (tx_data),
    .rx_stb  (rx_stb),
    .rx_data (rx_data),
    .spics_n (spics_n),
    .spick   (spick),
    .spido   (spido),
    .spidi   (spidi)
  );

  always #5 fclk = ~fclk;

  int cyc = 0;
  always @(posedge fclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // ---------------- slave model and event monitor ----------------
  logic [7:0] tx_q [64];     // tx_q[k-1] = data byte k sent by the master
  logic [7:0] ms_q [64];     // ms_q[0] answered during addr, ms_q[k] for byte k
  int         fr_n = 0;

  int         tx_seen, busy_cnt, ck_cs_viol, do_viol, rise_cnt;
  int         cs_rise_cyc, cs_fall_cyc;
  int         tx_cyc [$];
  int         rx_cyc [$];
  int         done_cyc [$];
  logic [7:0] rx_val [$];
  logic [7:0] mosi [$];
  logic [7:0] mosi_sh;
  logic       prev_ck, prev_do, prev_cs;

  function automatic logic miso_bit(input int i);
    if (i < 8 * (fr_n + 1)) return ms_q[i / 8][7 - (i % 8)];
    return 1'b0;
  endfunction

  initial begin
    tx_data = 8'h00;
    spidi   = 1'b0;
    prev_ck = 1'b0;
    prev_do = 1'b0;
    prev_cs = 1'b1;
    rise_cnt = 0;
    forever begin
      @(negedge fclk);
      tx_data = (tx_seen < 64) ? tx_q[tx_seen] : 8'h00;
      if (tx_ld) begin
        tx_cyc.push_back(cyc);
        tx_seen++;
      end
      if (rx_stb) begin
        rx_cyc.push_back(cyc);
        rx_val.push_back(rx_data);
      end
      if (done) done_cyc.push_back(cyc);
      if (busy) busy_cnt++;
      if (spics_n && spick) ck_cs_viol++;
      if (spick && prev_ck && spido != prev_do) do_viol++;
      if (!prev_cs && spics_n) cs_rise_cyc = cyc;
      if (prev_cs && !spics_n) cs_fall_cyc = cyc;
      if (spics_n) begin
        rise_cnt = 0;
      end else if (spick && !prev_ck) begin
        mosi_sh = {mosi_sh[6:0], spido};
        rise_cnt++;
        if (rise_cnt % 8 == 0) mosi.push_back(mosi_sh);
      end
      prev_ck = spick;
      prev_do = spido;
      prev_cs = spics_n;
      spidi   = miso_bit(rise_cnt);
    end
  end

  task automatic clear_monitor();
    tx_seen    = 0;
    busy_cnt   = 0;
    ck_cs_viol = 0;
    do_viol    = 0;
    tx_cyc.delete();
    rx_cyc.delete();
    done_cyc.delete();
    rx_val.delete();
    mosi.delete();
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i <= n; i++) ms_q[i] = 8'($urandom);
    for (int i = 0; i < n; i++)  tx_q[i] = 8'($urandom);
  endtask

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  // Runs one frame; called and returning at posedge+1 times. A normal frame
  // returns in the cycle right after done, so the next call starts back-to-back.
  task automatic run_frame(input logic [7:0] a, input int n, input int abort_off,
                           input bit busy_starts, input int idle_cyc,
                           input bit check_gap, input string tag);
    int c0, t, bad, tx_exp, rx_exp;
    repeat (idle_cyc) tick();
    fr_n = n;
    clear_monitor();
    t  = S + 16 * D * (n + 1) + H;
    c0 = cyc;
    start  = 1'b1;
    addr   = a;
    nbytes = 6'(n);
    tick();
    start  = 1'b0;
    addr   = 8'($urandom);
    nbytes = 6'($urandom);

    if (abort_off >= 1) begin
      while (cyc - c0 < abort_off) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check({tag, ".cs_n"},  int'(spics_n), 1);
      check({tag, ".spick"}, int'(spick),   0);
      check({tag, ".busy"},  int'(busy),    0);
      repeat (150) tick();
      tx_exp = 0;
      rx_exp = 0;
      for (int k = 1; k <= n; k++) begin
        if (S + 16 * D * k < abort_off) tx_exp++;
        if (S + 16 * D * k + 15 * D + 1 <= abort_off) rx_exp++;
      end
      check({tag, ".busy_len"}, busy_cnt, abort_off);
      check({tag, ".done_cnt"}, done_cyc.size(), 0);
      check({tag, ".tx_cnt"},   tx_cyc.size(), tx_exp);
      check({tag, ".rx_cnt"},   rx_val.size(), rx_exp);
      return;
    end

    while (done_cyc.size() == 0 && (cyc - c0) <= t + 50) begin
      start = busy_starts && ((cyc - c0) <= t) && ($urandom_range(0, 5) == 0);
      if (start) addr = 8'($urandom);
      tick();
    end
    start = 1'b0;

    check({tag, ".done_cnt"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0) check({tag, ".done_cyc"}, done_cyc[0] - c0, t);
    check({tag, ".busy_len"}, busy_cnt, t);
    check({tag, ".tx_cnt"}, tx_cyc.size(), n);
    bad = 0;
    foreach (tx_cyc[i]) if (tx_cyc[i] - c0 != S + 16 * D * (i + 1)) bad++;
    check({tag, ".tx_time"}, bad, 0);
    check({tag, ".rx_cnt"}, rx_val.size(), n);
    bad = 0;
    foreach (rx_val[i]) begin
      if (rx_val[i] != ms_q[i + 1]) bad++;
      if (rx_cyc[i] - c0 != S + 16 * D * (i + 1) + 15 * D + 1) bad++;
    end
    check({tag, ".rx_bytes"}, bad, 0);
    check({tag, ".mosi_cnt"}, mosi.size(), n + 1);
    bad = 0;
    foreach (mosi[i]) begin
      if (i == 0 && mosi[i] != a) bad++;
      if (i > 0 && mosi[i] != tx_q[i - 1]) bad++;
    end
    check({tag, ".mosi_bits"}, bad, 0);
    check({tag, ".ck_idle"},   ck_cs_viol, 0);
    check({tag, ".do_stable"}, do_viol, 0);
    if (check_gap) check({tag, ".cs_gap"}, cs_fall_cyc - cs_rise_cyc, idle_cyc + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst    = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    addr   = 8'h00;
    nbytes = 6'd0;
    for (int i = 0; i < 64; i++) begin
      tx_q[i] = 8'h00;
      ms_q[i] = 8'h00;
    end
    clear_monitor();
    repeat (4) tick();
    rst = 1'b0;
    tick();
    check("rst.busy",    int'(busy),    0);
    check("rst.done",    int'(done),    0);
    check("rst.tx_ld",   int'(tx_ld),   0);
    check("rst.rx_stb",  int'(rx_stb),  0);
    check("rst.rx_data", int'(rx_data), 0);
    check("rst.cs_n",    int'(spics_n), 1);
    check("rst.spick",   int'(spick),   0);
    check("rst.spido",   int'(spido),   0);

    // Address-only frame.
    fill_random(0);
    run_frame(8'hA5, 0, 0, 1'b0, 0, 1'b0, "addr_only");

    // Two data bytes with fixed slave answers.
    tx_q[0] = 8'h3C; tx_q[1] = 8'hC3;
    ms_q[0] = 8'h00; ms_q[1] = 8'h5A; ms_q[2] = 8'hA5;
    run_frame(8'h10, 2, 0, 1'b0, 2, 1'b1, "two_bytes");
    check("two_bytes.rx_hold", int'(rx_data), 8'hA5);

    // Back-to-back frame with stray start pulses while busy.
    fill_random(3);
    run_frame(8'($urandom), 3, 0, 1'b1, 0, 1'b1, "b2b");

    // Maximum length frame, incrementing tx pattern.
    fill_random(63);
    for (int i = 0; i < 63; i++) tx_q[i] = 8'(i + 1);
    run_frame(8'h3F, 63, 0, 1'b0, 0, 1'b1, "max_len");

    // Abort during a spick-high phase of data byte 1, then a normal frame.
    fill_random(3);
    run_frame(8'h77, 3, S + 16 * D + 4 * D + D + 1, 1'b0, 1, 1'b0, "abort");
    fill_random(1);
    run_frame(8'($urandom), 1, 0, 1'b0, 0, 1'b0, "post_abort");

    // Abort and start together while idle: nothing starts.
    tick();
    clear_monitor();
    start = 1'b1; abort = 1'b1; addr = 8'h42; nbytes = 6'd1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort_start.cs_n", int'(spics_n), 1);
    repeat (5) tick();
    check("abort_start.busy_cnt", busy_cnt, 0);

    // Reset in the middle of a frame after the first rx_stb.
    fill_random(2);
    ms_q[1] = 8'h96;
    fr_n = 2;
    clear_monitor();
    c0 = cyc;
    start = 1'b1; addr = 8'h5C; nbytes = 6'd2;
    tick();
    start = 1'b0;
    while (cyc - c0 < S + 16 * D + 15 * D + 4) tick();
    check("mid_rst.rx_before", int'(rx_data), 8'h96);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst.busy",    int'(busy),    0);
    check("mid_rst.done",    int'(done),    0);
    check("mid_rst.tx_ld",   int'(tx_ld),   0);
    check("mid_rst.rx_stb",  int'(rx_stb),  0);
    check("mid_rst.rx_data", int'(rx_data), 0);
    check("mid_rst.cs_n",    int'(spics_n), 1);
    check("mid_rst.spick",   int'(spick),   0);
    check("mid_rst.spido",   int'(spido),   0);
    fill_random(2);
    run_frame(8'($urandom), 2, 0, 1'b0, 1, 1'b0, "post_rst");

    // Randomised frames.
    for (int f = 0; f < 8; f++) begin
      int n, idle;
      n    = $urandom_range(0, 6);
      idle = $urandom_range(0, 2);
      fill_random(n);
      run_frame(8'($urandom), n, 0, 1'($urandom_range(0, 1)), idle, 1'b1,
                $sformatf("rand%0d", f));
    end

    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
